// File: rtl/key_num_entry_if.sv
// Keypad-to-numeric-entry bus.
// The master side is the keypad scanner and display/consumer logic.
// The slave side is the key_num_entry block.
interface key_num_entry_if #(
  parameter int DIGITS = 4,
  parameter int NUM_W  = 14
);
  localparam int CNT_W = $clog2(DIGITS + 1);

  logic                  key_en;
  logic [3:0]            key_data;
  logic [4*DIGITS-1:0]   bcd;
  logic [CNT_W-1:0]      digit_cnt;
  logic                  busy;
  logic                  num_valid;
  logic [NUM_W-1:0]      num;

  modport master (
    output key_en, key_data,
    input  bcd, digit_cnt, busy, num_valid, num
  );

  modport slave (
    input  key_en, key_data,
    output bcd, digit_cnt, busy, num_valid, num
  );
endinterface

// File: rtl/key_num_entry.sv
// Numeric-entry stage for a 4x4 keypad.
// Decimal digits are collected into a BCD buffer, with backspace and clear.
// On Enter, the buffered digits are converted to binary with one
// multiply-by-10-and-add step per cycle, and the result is flagged with a
// one-cycle valid pulse.
module key_num_entry #(
  parameter int DIGITS = 4,
  parameter int NUM_W  = 14
) (
  input  logic             clk,
  input  logic             rstn,
  key_num_entry_if.slave   bus
);
  localparam int BCD_W = 4 * DIGITS;
  localparam int CNT_W = $clog2(DIGITS + 1);
  localparam int TOP   = BCD_W - 4;

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_CONV = 1'b1;

  localparam logic [3:0] K_BKSP  = 4'hA;
  localparam logic [3:0] K_CLEAR = 4'hB;
  localparam logic [3:0] K_ENTER = 4'hE;

  logic [0:0]       state_q,     state_d;
  logic [BCD_W-1:0] bcd_q,       bcd_d;
  logic [CNT_W-1:0] cnt_q,       cnt_d;
  logic [BCD_W-1:0] snap_q,      snap_d;
  logic [CNT_W-1:0] conv_cnt_q,  conv_cnt_d;
  logic [NUM_W-1:0] acc_q,       acc_d;
  logic [NUM_W-1:0] num_q,       num_d;
  logic             num_valid_q, num_valid_d;
  logic [NUM_W-1:0] acc_next;
  int               shamt;

  // acc*10 + d, formed as (acc<<3)+(acc<<1) so no multiplier is needed.
  // The snapshot is left-aligned, so its top nibble is always the next digit.
  assign acc_next = (acc_q << 3) + (acc_q << 1) + NUM_W'(snap_q[TOP +: 4]);

  // Next-state logic: key decode in IDLE, and one conversion step per cycle in CONV.
  // NOTE: every variable gets a default value first. That way, no path through
  // the case leaves one unassigned and infers a latch.
  always_comb begin
    state_d     = state_q;
    bcd_d       = bcd_q;
    cnt_d       = cnt_q;
    snap_d      = snap_q;
    conv_cnt_d  = conv_cnt_q;
    acc_d       = acc_q;
    num_d       = num_q;
    num_valid_d = 1'b0;
    shamt       = 0;

    case (state_q)
      S_IDLE: begin
        if (bus.key_en) begin
          if (bus.key_data <= 4'd9) begin
            // A digit shifts in at the low nibble. It is dropped once the buffer is full.
            if (cnt_q < CNT_W'(DIGITS)) begin
              bcd_d = (bcd_q << 4) | BCD_W'(bus.key_data);
              cnt_d = cnt_q + CNT_W'(1);
            end
          end else begin
            case (bus.key_data)
              K_BKSP: begin
                if (cnt_q != '0) begin
                  bcd_d = bcd_q >> 4;
                  cnt_d = cnt_q - CNT_W'(1);
                end
              end
              K_CLEAR: begin
                bcd_d = '0;
                cnt_d = '0;
              end
              K_ENTER: begin
                if (cnt_q != '0) begin
                  // Left-align the valid digits, so the most significant digit is at the top.
                  shamt      = 4 * (DIGITS - int'(cnt_q));
                  snap_d     = bcd_q << shamt;
                  conv_cnt_d = cnt_q;
                  acc_d      = '0;
                  bcd_d      = '0;
                  cnt_d      = '0;
                  state_d    = S_CONV;
                end
              end
              default: ;
            endcase
          end
        end
      end

      S_CONV: begin
        acc_d      = acc_next;
        snap_d     = snap_q << 4;
        conv_cnt_d = conv_cnt_q - CNT_W'(1);
        if (conv_cnt_q == CNT_W'(1)) begin
          num_d       = acc_next;
          num_valid_d = 1'b1;
          state_d     = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  // State registers. A reset also aborts any conversion that is in flight.
  // NOTE: sequential state uses non-blocking assignments, so every register
  // samples the values from before the edge.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= S_IDLE;
      bcd_q       <= '0;
      cnt_q       <= '0;
      snap_q      <= '0;
      conv_cnt_q  <= '0;
      acc_q       <= '0;
      num_q       <= '0;
      num_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      bcd_q       <= bcd_d;
      cnt_q       <= cnt_d;
      snap_q      <= snap_d;
      conv_cnt_q  <= conv_cnt_d;
      acc_q       <= acc_d;
      num_q       <= num_d;
      num_valid_q <= num_valid_d;
    end
  end

  assign bus.bcd       = bcd_q;
  assign bus.digit_cnt = cnt_q;
  assign bus.busy      = (state_q == S_CONV);
  assign bus.num_valid = num_valid_q;
  assign bus.num       = num_q;
endmodule

// File: tb/tb_key_num_entry.sv
// Directed bench for key_num_entry, with DIGITS=4 and NUM_W=14.
// Inputs change on the falling edge, and outputs are sampled on the falling edge.
module tb_key_num_entry;
  logic clk;
  logic rstn;
  int   checks;
  int   failures;

  key_num_entry_if #(.DIGITS(4), .NUM_W(14)) bus ();

  key_num_entry #(.DIGITS(4), .NUM_W(14)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Strobe one key for one cycle. The task is entered and left at a falling edge.
  task automatic key(input logic [3:0] k);
    bus.key_en   = 1'b1;
    bus.key_data = k;
    @(negedge clk);
    bus.key_en   = 1'b0;
    bus.key_data = 4'h0;
  endtask

  // Wait for num_valid. cyc counts the edges since the Enter edge, starting from start_cyc.
  task automatic wait_valid(input string tag, input int start_cyc, input int exp_lat,
                            input logic [31:0] exp_num);
    int cyc;
    cyc = start_cyc;
    while (bus.num_valid !== 1'b1 && cyc < 20) begin
      check({tag, "_busy"}, 32'(bus.busy), 32'd1);
      @(negedge clk);
      cyc++;
    end
    check({tag, "_lat"}, 32'(cyc), 32'(exp_lat));
    check({tag, "_num"}, 32'(bus.num), exp_num);
    check({tag, "_busy_done"}, 32'(bus.busy), 32'd0);
  endtask

  initial begin
    int pulses;
    checks       = 0;
    failures     = 0;
    rstn         = 1'b0;
    bus.key_en   = 1'b0;
    bus.key_data = 4'h0;
    repeat (3) @(negedge clk);
    check("rst_bcd", 32'(bus.bcd), 32'h0);
    check("rst_cnt", 32'(bus.digit_cnt), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_valid", 32'(bus.num_valid), 32'd0);
    check("rst_num", 32'(bus.num), 32'd0);
    rstn = 1'b1;
    @(negedge clk);

    // Enter 1,2,3 and convert.
    key(4'h1); key(4'h2); key(4'h3);
    check("t1_bcd", 32'(bus.bcd), 32'h0123);
    check("t1_cnt", 32'(bus.digit_cnt), 32'd3);
    key(4'hE);
    check("t1_busy", 32'(bus.busy), 32'd1);
    check("t1_bcd_clr", 32'(bus.bcd), 32'h0);
    check("t1_cnt_clr", 32'(bus.digit_cnt), 32'd0);
    check("t1_novalid", 32'(bus.num_valid), 32'd0);
    wait_valid("t1", 0, 3, 32'd123);
    @(negedge clk);
    check("t1_pulse_end", 32'(bus.num_valid), 32'd0);
    check("t1_num_hold", 32'(bus.num), 32'd123);

    // Full buffer: the fifth 9 is ignored, and the result is the maximum value.
    repeat (5) key(4'h9);
    check("t2_bcd", 32'(bus.bcd), 32'h9999);
    check("t2_cnt", 32'(bus.digit_cnt), 32'd4);
    key(4'hE);
    wait_valid("t2", 0, 4, 32'd9999);

    // Backspace and clear.
    key(4'h4); key(4'h5); key(4'hA); key(4'h7);
    check("t3_bcd", 32'(bus.bcd), 32'h0047);
    check("t3_cnt", 32'(bus.digit_cnt), 32'd2);
    key(4'hB);
    check("t3_clr_bcd", 32'(bus.bcd), 32'h0);
    check("t3_clr_cnt", 32'(bus.digit_cnt), 32'd0);
    key(4'hA);
    key(4'hE);
    check("t3_empty_cnt", 32'(bus.digit_cnt), 32'd0);
    check("t3_empty_busy", 32'(bus.busy), 32'd0);
    pulses = 0;
    for (int i = 0; i < 6; i++) begin
      if (bus.num_valid === 1'b1) pulses++;
      @(negedge clk);
    end
    check("t3_no_pulse", 32'(pulses), 32'd0);
    check("t3_num_hold", 32'(bus.num), 32'd9999);

    // A key strobed during a conversion is dropped. A key at E+4 is accepted.
    key(4'h8); key(4'h0); key(4'h0);
    key(4'hE);
    key(4'h5);
    wait_valid("t4", 1, 3, 32'd800);
    check("t4_bcd_drop", 32'(bus.bcd), 32'h0);
    key(4'h6);
    check("t4_pulse_end", 32'(bus.num_valid), 32'd0);
    check("t4_bcd6", 32'(bus.bcd), 32'h0006);
    check("t4_cnt6", 32'(bus.digit_cnt), 32'd1);

    // Leading zeros count as digits. Codes C, D and F are ignored.
    key(4'hB);
    key(4'h0); key(4'h0); key(4'h7); key(4'hC); key(4'hD); key(4'hF);
    check("t5_cnt", 32'(bus.digit_cnt), 32'd3);
    check("t5_bcd", 32'(bus.bcd), 32'h0007);
    key(4'hE);
    wait_valid("t5", 0, 3, 32'd7);

    // A reset in the middle of a conversion aborts it.
    @(negedge clk);
    key(4'h1); key(4'h2); key(4'h3); key(4'h4);
    key(4'hE);
    @(posedge clk);
    @(posedge clk);
    #1 rstn = 1'b0;
    #1;
    check("t6_busy", 32'(bus.busy), 32'd0);
    check("t6_num", 32'(bus.num), 32'd0);
    check("t6_valid", 32'(bus.num_valid), 32'd0);
    check("t6_bcd", 32'(bus.bcd), 32'h0);
    check("t6_cnt", 32'(bus.digit_cnt), 32'd0);
    @(negedge clk);
    rstn = 1'b1;
    pulses = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (bus.num_valid === 1'b1) pulses++;
    end
    check("t6_no_pulse", 32'(pulses), 32'd0);
    check("t6_num_after", 32'(bus.num), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
